bcd_conv_arbiter: RTL and testbench

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_dabble_step.sv | 22 ++
 rtl/bcd_conv_arbiter.sv | 144 ++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared widths and FSM state encoding for the binary-to-BCD converter slice.
package bcd_pkg;
  localparam int BIN_W = 12;
  localparam int BCD_W = 12;
  localparam int DIG_W = 4;
  localparam int NDIG  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;
endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to each digit >= 5, then shift {digits,operand} left by one.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [NDIG*DIG_W-1:0] dig_i,
  input  logic [BIN_W-1:0]      op_i,
  output logic [NDIG*DIG_W-1:0] dig_o,
  output logic [BIN_W-1:0]      op_o
);

  logic [NDIG*DIG_W-1:0] adj;

  always_comb begin
    adj = dig_i;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (dig_i[i*DIG_W +: DIG_W] >= DIG_W'(5))
        adj[i*DIG_W +: DIG_W] = dig_i[i*DIG_W +: DIG_W] + DIG_W'(3);
    end
    {dig_o, op_o} = {adj[NDIG*DIG_W-2:0], op_i, 1'b0};
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Two-requester round-robin arbiter feeding a sequential 12-bit binary-to-BCD converter.
// Define BCD_SAT_EN to saturate operands >999 to 999; otherwise the low three digits are kept.
module bcd_conv_arbiter
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [BIN_W-1:0] bin0,
  input  logic [BIN_W-1:0] bin1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [BCD_W-1:0] bcd_out,
  output logic             ovf,
  output logic             done,
  output logic             done_id
);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  state_e                state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic [NDIG*DIG_W-1:0] digits_q, digits_d;
  logic [BIN_W-1:0]      op_q, op_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic [1:0]            grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic                  done_id_q, done_id_d;

  logic                  win;
  logic                  thou_nz;
  logic [NDIG*DIG_W-1:0] step_dig;
  logic [BIN_W-1:0]      step_op;

  // Asynchronous assertion, release aligned to clk through two flops.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  bcd_dabble_step u_step (
    .dig_i (digits_q),
    .op_i  (op_q),
    .dig_o (step_dig),
    .op_o  (step_op)
  );

  assign thou_nz = (digits_q[NDIG*DIG_W-1 -: DIG_W] != '0);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    digits_d  = digits_q;
    op_d      = op_q;
    last_d    = last_q;
    owner_d   = owner_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_id_d = done_id_q;
    grant_d   = '0;
    done_d    = 1'b0;
    win       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req != '0) begin
          // Requester 0 wins when alone or when requester 1 was granted last.
          win      = !(req[0] && (!req[1] || last_q));
          grant_d  = win ? 2'b10 : 2'b01;
          op_d     = win ? bin1 : bin0;
          digits_d = '0;
          count_d  = '0;
          owner_d  = win;
          last_d   = win;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        digits_d = step_dig;
        op_d     = step_op;
        count_d  = count_q + 4'd1;
        if (count_q == 4'd11) state_d = S_DONE;
      end
      S_DONE: begin
`ifdef BCD_SAT_EN
        bcd_d = thou_nz ? BCD_W'(12'h999) : digits_q[BCD_W-1:0];
`else
        bcd_d = digits_q[BCD_W-1:0];
`endif
        ovf_d     = thou_nz;
        done_id_d = owner_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      digits_q  <= '0;
      op_q      <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      digits_q  <= digits_d;
      op_q      <= op_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Randomised self-checking bench for bcd_conv_arbiter against an arithmetic reference model.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [11:0] bin0 = '0;
  logic [11:0] bin1 = '0;
  logic [1:0]  grant;
  logic        busy;
  logic [11:0] bcd_out;
  logic        ovf;
  logic        done;
  logic        done_id;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_conv_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .bin0    (bin0),
    .bin1    (bin1),
    .grant   (grant),
    .busy    (busy),
    .bcd_out (bcd_out),
    .ovf     (ovf),
    .done    (done),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  // Expected {ovf, bcd} from plain decimal arithmetic.
  function automatic logic [12:0] ref_conv(input int v);
    int   m;
    logic o;
    o = (v > 999);
`ifdef BCD_SAT_EN
    m = o ? 999 : v;
`else
    m = v % 1000;
`endif
    return {o, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [1:0] onehot(input int id);
    return (id != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_grant(output bit tmo, output logic [1:0] g);
    tmo = 1'b1;
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != '0) begin
        g = grant;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit tmo, output int cyc);
    tmo = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic convert(input int id, input logic [11:0] val, output bit tmo,
                         output logic [1:0] g, output int lat);
    @(negedge clk);
    if (id != 0) bin1 = val; else bin0 = val;
    req[id] = 1'b1;
    lat = 0;
    wait_grant(tmo, g);
    if (!tmo) wait_done(tmo, lat);
    req[id] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({grant, busy, bcd_out, ovf, done, done_id} !== 18'd0)
      $display("FAIL reset_hold got g=%b b=%b bcd=%h o=%b d=%b id=%b want all zero",
               grant, busy, bcd_out, ovf, done, done_id);
    else n_pass++;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({grant, busy, done} !== 4'd0)
      $display("FAIL reset_idle got g=%b b=%b d=%b want 0", grant, busy, done);
    else n_pass++;
  endtask

  task automatic test_single();
    int lat = 0;
    int gcnt = 1;
    bit tmo;
    logic [1:0] g;
    @(negedge clk);
    bin0 = 12'd255;
    req = 2'b01;
    wait_grant(tmo, g);
    n_checks++;
    if (tmo || g !== 2'b01) $display("FAIL single_grant got %b tmo=%0d want 01", g, tmo);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (grant != '0) gcnt++;
      if (done) break;
    end
    req = '0;
    n_checks++;
    if (lat !== 13 || !done) $display("FAIL single_latency got %0d done=%b want 13", lat, done);
    else n_pass++;
    n_checks++;
    if ({bcd_out, ovf, done_id} !== {12'h255, 1'b0, 1'b0})
      $display("FAIL single_result got %h o=%b id=%b want 255 0 0", bcd_out, ovf, done_id);
    else n_pass++;
    n_checks++;
    if (gcnt !== 1) $display("FAIL single_grant_once got %0d want 1", gcnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) $display("FAIL single_pulse got d=%b b=%b want 00", done, busy);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit tmo;
    int cyc;
    logic [1:0] g;
    do_reset();
    @(negedge clk);
    bin0 = 12'd42;
    bin1 = 12'd999;
    req = 2'b11;
    wait_grant(tmo, g);
    n_checks++;
    if (tmo || g !== 2'b01) $display("FAIL simul_first_grant got %b want 01", g);
    else n_pass++;
    wait_done(tmo, cyc);
    n_checks++;
    if (tmo || {bcd_out, ovf, done_id} !== {12'h042, 1'b0, 1'b0})
      $display("FAIL simul_first got %h o=%b id=%b tmo=%0d want 042 0 0", bcd_out, ovf, done_id, tmo);
    else n_pass++;
    req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b10) $display("FAIL simul_second_grant got %b want 10", grant);
    else n_pass++;
    wait_done(tmo, cyc);
    req[1] = 1'b0;
    n_checks++;
    if (tmo || cyc !== 13 || {bcd_out, ovf, done_id} !== {12'h999, 1'b0, 1'b1})
      $display("FAIL simul_second got %h o=%b id=%b lat=%0d want 999 0 1 lat 13",
               bcd_out, ovf, done_id, cyc);
    else n_pass++;
  endtask

  task automatic test_overflow();
    bit tmo;
    int lat;
    logic [1:0] g;
    logic [12:0] exp;
    exp = ref_conv(4095);
    convert(1, 12'd4095, tmo, g, lat);
    n_checks++;
    if (tmo || g !== 2'b10 || {ovf, bcd_out, done_id} !== {exp, 1'b1})
      $display("FAIL overflow_4095 got %h o=%b id=%b g=%b want %h o=%b id=1",
               bcd_out, ovf, done_id, g, exp[11:0], exp[12]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit tmo;
    int lat;
    int dcnt = 0;
    logic [1:0] g;
    logic [11:0] v;
    logic [12:0] exp;
    @(negedge clk);
    bin0 = 12'($urandom_range(0, 999));
    req = 2'b01;
    wait_grant(tmo, g);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({grant, busy, bcd_out, ovf, done, done_id} !== 18'd0)
      $display("FAIL midreset_outputs got g=%b b=%b bcd=%h o=%b d=%b id=%b want zero",
               grant, busy, bcd_out, ovf, done, done_id);
    else n_pass++;
    req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    n_checks++;
    if (dcnt !== 0 || {busy, bcd_out, ovf, done_id} !== 15'd0)
      $display("FAIL midreset_no_done got dones=%0d b=%b bcd=%h want 0", dcnt, busy, bcd_out);
    else n_pass++;
    v = 12'($urandom_range(0, 4095));
    exp = ref_conv(int'(v));
    convert(0, v, tmo, g, lat);
    n_checks++;
    if (tmo || g !== 2'b01 || lat !== 13 || {ovf, bcd_out, done_id} !== {exp, 1'b0})
      $display("FAIL midreset_recover op=%0d got %h o=%b id=%b lat=%0d want %h o=%b",
               v, bcd_out, ovf, done_id, lat, exp[11:0], exp[12]);
    else n_pass++;
  endtask

  task automatic test_late_request();
    bit tmo;
    int cyc;
    int late_g = 0;
    logic [1:0] g;
    logic [11:0] a, b;
    a = 12'($urandom_range(0, 4095));
    b = 12'($urandom_range(0, 4095));
    @(negedge clk);
    bin0 = a;
    req = 2'b01;
    wait_grant(tmo, g);
    repeat (3) @(negedge clk);
    bin1 = b;
    req[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (grant != '0) late_g++;
      if (done) break;
    end
    n_checks++;
    if (late_g !== 0) $display("FAIL late_no_grant got %0d grants while busy want 0", late_g);
    else n_pass++;
    n_checks++;
    if ({ovf, bcd_out, done_id} !== {ref_conv(int'(a)), 1'b0})
      $display("FAIL late_first op=%0d got %h o=%b id=%b", a, bcd_out, ovf, done_id);
    else n_pass++;
    req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b10) $display("FAIL late_grant got %b want 10", grant);
    else n_pass++;
    wait_done(tmo, cyc);
    req[1] = 1'b0;
    n_checks++;
    if (tmo || {ovf, bcd_out, done_id} !== {ref_conv(int'(b)), 1'b1})
      $display("FAIL late_second op=%0d got %h o=%b id=%b", b, bcd_out, ovf, done_id);
    else n_pass++;
  endtask

  task automatic test_boundary();
    int vals[8] = '{0, 9, 10, 99, 100, 999, 1000, 4095};
    bit tmo;
    int lat;
    logic [1:0] g;
    logic [12:0] exp;
    foreach (vals[k]) begin
      exp = ref_conv(vals[k]);
      convert(0, 12'(vals[k]), tmo, g, lat);
      n_checks++;
      if (tmo || g !== 2'b01 || lat !== 13 || {ovf, bcd_out, done_id} !== {exp, 1'b0})
        $display("FAIL boundary_%0d got %h o=%b id=%b lat=%0d want %h o=%b",
                 vals[k], bcd_out, ovf, done_id, lat, exp[11:0], exp[12]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit tmo;
    int cyc;
    int pat, first, second;
    logic [1:0] g;
    logic [11:0] v[2];
    int last_id;
    do_reset();
    last_id = 1;
    for (int it = 0; it < 12; it++) begin
      pat = int'($urandom_range(1, 3));
      v[0] = 12'($urandom_range(0, 4095));
      v[1] = 12'($urandom_range(0, 4095));
      @(negedge clk);
      bin0 = v[0];
      bin1 = v[1];
      req = 2'(pat);
      first = (pat == 3) ? 1 - last_id : ((pat == 2) ? 1 : 0);
      second = 1 - first;
      wait_grant(tmo, g);
      n_checks++;
      if (tmo || g !== onehot(first))
        $display("FAIL rand%0d_grant got %b want %b", it, g, onehot(first));
      else n_pass++;
      wait_done(tmo, cyc);
      req[first] = 1'b0;
      n_checks++;
      if (tmo || cyc !== 13 || {ovf, bcd_out, done_id} !== {ref_conv(int'(v[first])), 1'(first)})
        $display("FAIL rand%0d_first op=%0d got %h o=%b id=%b lat=%0d",
                 it, v[first], bcd_out, ovf, done_id, cyc);
      else n_pass++;
      last_id = first;
      if (pat == 3) begin
        wait_done(tmo, cyc);
        req[second] = 1'b0;
        n_checks++;
        if (tmo || cyc !== 14 || {ovf, bcd_out, done_id} !== {ref_conv(int'(v[second])), 1'(second)})
          $display("FAIL rand%0d_second op=%0d got %h o=%b id=%b lat=%0d",
                   it, v[second], bcd_out, ovf, done_id, cyc);
        else n_pass++;
        last_id = second;
      end
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_late_request();
    test_boundary();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
